// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an optional
// two-entry skid buffer (main register M drives the outputs, skid register S absorbs one extra beat).
module pipe_stage_buf #(
    parameter int DATA_W    = 16,
    parameter int CTRL_W    = 4,
    parameter int SKID      = 1,
    parameter int FLUSH_CLR = 1
) (
    input  logic              CLOCK,
    input  logic              CLEAR,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int PW = DATA_W + CTRL_W;

    logic          r_mValid;
    logic          r_sValid;
    logic [PW-1:0] r_mPayload;
    logic [PW-1:0] r_sPayload;

    logic          w_mValidNext;
    logic          w_sValidNext;
    logic [PW-1:0] w_mPayloadNext;
    logic [PW-1:0] w_sPayloadNext;
    logic          w_accept;
    logic          w_emit;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = r_mValid & out_ready;

    // Skid mode: ready is a pure register output, so S must take the beat that was already in flight.
    generate
        if (SKID != 0) begin : g_skidReady
            assign in_ready = ~r_sValid;
        end else begin : g_singleReady
            assign in_ready = ~r_mValid | out_ready;
        end
    endgenerate

    always_comb begin
        w_mValidNext   = r_mValid;
        w_sValidNext   = r_sValid;
        w_mPayloadNext = r_mPayload;
        w_sPayloadNext = r_sPayload;
        if (flush) begin
            w_mValidNext = 1'b0;
            w_sValidNext = 1'b0;
            if (FLUSH_CLR != 0) begin
                w_mPayloadNext = '0;
                w_sPayloadNext = '0;
            end
        end else if ((SKID != 0) && w_emit && r_sValid) begin
            // in_ready is low while S is full, so no new beat can arrive in this branch.
            w_mPayloadNext = r_sPayload;
            w_sValidNext   = 1'b0;
        end else if (w_accept && (!r_mValid || w_emit)) begin
            w_mValidNext   = 1'b1;
            w_mPayloadNext = {in_ctrl, in_data};
        end else if ((SKID != 0) && w_accept) begin
            w_sValidNext   = 1'b1;
            w_sPayloadNext = {in_ctrl, in_data};
        end else if (w_emit) begin
            w_mValidNext = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            r_mValid   <= 1'b0;
            r_sValid   <= 1'b0;
            r_mPayload <= '0;
            r_sPayload <= '0;
        end else begin
            r_mValid   <= w_mValidNext;
            r_sValid   <= w_sValidNext;
            r_mPayload <= w_mPayloadNext;
            r_sPayload <= w_sPayloadNext;
        end
    end

    // S is only ever filled while M is full, so the two valid bits sum without overflow.
    assign occupancy = {r_mValid & r_sValid, r_mValid ^ r_sValid};
    assign out_valid = r_mValid;
    assign out_data  = r_mPayload[DATA_W-1:0];
    assign out_ctrl  = r_mPayload[PW-1:DATA_W];

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a skid instance (unit 0) and a single-register instance (unit 1),
// exercised one at a time against a queue of beats accepted but not yet delivered.
module tb_pipe_stage_buf;

    logic CLOCK = 1'b0;
    logic CLEAR;
    always #5 CLOCK = ~CLOCK;

    logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
    logic [15:0] aInData, aOutData;
    logic [3:0]  aInCtrl, aOutCtrl;
    logic [1:0]  aOccupancy;

    logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
    logic [15:0] bInData, bOutData;
    logic [3:0]  bInCtrl, bOutCtrl;
    logic [1:0]  bOccupancy;

    pipe_stage_buf #(.DATA_W(16), .CTRL_W(4), .SKID(1), .FLUSH_CLR(1)) dutSkid (
        .CLOCK(CLOCK), .CLEAR(CLEAR), .flush(aFlush),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_ctrl(aInCtrl),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .out_ctrl(aOutCtrl),
        .occupancy(aOccupancy)
    );

    pipe_stage_buf #(.DATA_W(16), .CTRL_W(4), .SKID(0), .FLUSH_CLR(1)) dutSingle (
        .CLOCK(CLOCK), .CLEAR(CLEAR), .flush(bFlush),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_ctrl(bInCtrl),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .out_ctrl(bOutCtrl),
        .occupancy(bOccupancy)
    );

    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCount = 0;
    logic [19:0] expQ[$];
    logic [19:0] lastOut[2];

    function automatic logic [3:0] ctrlOf(input logic [15:0] d);
        return d[3:0] ^ d[15:12];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle on the selected unit: drive just after the falling edge, check the model
    // shortly afterwards, then update the scoreboard with what the coming rising edge will do.
    task automatic applyStimulus(input int unit, input logic v, input logic [15:0] d, input logic [3:0] c,
                                 input logic ordy, input logic fl, output logic accepted);
        logic        expReady, expValid, emit, obsReady, obsValid;
        logic [1:0]  obsOcc;
        logic [19:0] obsPayload, expPayload;
        if (unit == 0) begin
            aInValid = v; aInData = d; aInCtrl = c; aOutReady = ordy; aFlush = fl;
            bInValid = 1'b0; bOutReady = 1'b0; bFlush = 1'b0;
        end else begin
            bInValid = v; bInData = d; bInCtrl = c; bOutReady = ordy; bFlush = fl;
            aInValid = 1'b0; aOutReady = 1'b0; aFlush = 1'b0;
        end
        #2;
        if (unit == 0) begin
            obsReady = aInReady; obsValid = aOutValid; obsOcc = aOccupancy; obsPayload = {aOutCtrl, aOutData};
        end else begin
            obsReady = bInReady; obsValid = bOutValid; obsOcc = bOccupancy; obsPayload = {bOutCtrl, bOutData};
        end
        expValid   = (expQ.size() > 0);
        expReady   = (unit == 0) ? (expQ.size() < 2) : (!expValid || ordy);
        expPayload = expValid ? expQ[0] : lastOut[unit];
        checkOutput($sformatf("u%0d inReady", unit), {31'd0, obsReady}, {31'd0, expReady});
        checkOutput($sformatf("u%0d outValid", unit), {31'd0, obsValid}, {31'd0, expValid});
        checkOutput($sformatf("u%0d occupancy", unit), {30'd0, obsOcc}, expQ.size());
        checkOutput($sformatf("u%0d outPayload", unit), {12'd0, obsPayload}, {12'd0, expPayload});
        emit     = expValid & ordy;
        accepted = v & expReady;
        if (emit) lastOut[unit] = expQ.pop_front();
        if (fl) begin
            expQ.delete();
            lastOut[unit] = '0;
        end else if (accepted) begin
            expQ.push_back({c, d});
        end
        @(posedge CLOCK);
        @(negedge CLOCK);
        cycleCount++;
    endtask

    task automatic offer(input int unit, input logic [15:0] d, input logic ordy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 10) begin
            applyStimulus(unit, 1'b1, d, ctrlOf(d), ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) checkOutput($sformatf("u%0d offerTimeout %0h", unit, d), 32'd0, 32'd1);
    endtask

    task automatic drain(input int unit);
        logic acc;
        int   tries;
        tries = 0;
        while (expQ.size() > 0 && tries < 10) begin
            applyStimulus(unit, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, acc);
            tries++;
        end
        checkOutput($sformatf("u%0d drainTimeout", unit), expQ.size(), 32'd0);
        applyStimulus(unit, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " aOutValid"}, {31'd0, aOutValid}, 32'd0);
        checkOutput({tag, " aOutData"}, {16'd0, aOutData}, 32'd0);
        checkOutput({tag, " aOutCtrl"}, {28'd0, aOutCtrl}, 32'd0);
        checkOutput({tag, " aOccupancy"}, {30'd0, aOccupancy}, 32'd0);
        checkOutput({tag, " aInReady"}, {31'd0, aInReady}, 32'd1);
        checkOutput({tag, " bOutValid"}, {31'd0, bOutValid}, 32'd0);
        checkOutput({tag, " bOutData"}, {16'd0, bOutData}, 32'd0);
        checkOutput({tag, " bOccupancy"}, {30'd0, bOccupancy}, 32'd0);
        checkOutput({tag, " bInReady"}, {31'd0, bInReady}, 32'd1);
    endtask

    initial begin
        logic acc;
        int   t0;
        lastOut[0] = '0;
        lastOut[1] = '0;
        aFlush = 0; aInValid = 0; aInData = 0; aInCtrl = 0; aOutReady = 0;
        bFlush = 0; bInValid = 0; bInData = 0; bInCtrl = 0; bOutReady = 0;
        CLEAR = 1'b1;
        #1 CLEAR = 1'b0;

        // Reset held with random activity on every input.
        @(negedge CLOCK);
        for (int i = 0; i < 4; i++) begin
            aInValid = 1'($urandom); aInData = 16'($urandom); aInCtrl = 4'($urandom);
            aOutReady = 1'($urandom); aFlush = 1'($urandom);
            bInValid = 1'($urandom); bInData = 16'($urandom); bInCtrl = 4'($urandom);
            bOutReady = 1'($urandom); bFlush = 1'($urandom);
            #2;
            checkIdle($sformatf("reset%0d", i));
            @(negedge CLOCK);
        end
        CLEAR = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, acc);

        // Back-to-back streaming through the skid instance.
        t0 = cycleCount;
        for (int i = 0; i < 8; i++) offer(0, 16'h1111 + 16'(i), 1'b1);
        checkOutput("streamCycles", cycleCount - t0, 32'd8);
        drain(0);

        // Stall: 0x2222 lands in S, 0x3333 waits upstream.
        offer(0, 16'h1111, 1'b1);
        offer(0, 16'h2222, 1'b0);
        applyStimulus(0, 1'b1, 16'h3333, ctrlOf(16'h3333), 1'b0, 1'b0, acc);
        checkOutput("stallHold3333", {31'd0, acc}, 32'd0);
        offer(0, 16'h3333, 1'b1);
        drain(0);

        // Flush with both entries full and a beat offered.
        offer(0, 16'hAAAA, 1'b1);
        offer(0, 16'hBBBB, 1'b0);
        applyStimulus(0, 1'b1, 16'h4444, ctrlOf(16'h4444), 1'b0, 1'b1, acc);
        drain(0);

        // Flush while a beat is emitted and another is accepted in the same cycle.
        offer(0, 16'hCCCC, 1'b1);
        applyStimulus(0, 1'b1, 16'h4445, ctrlOf(16'h4445), 1'b1, 1'b1, acc);
        checkOutput("flushAcceptHandshake", {31'd0, acc}, 32'd1);
        drain(0);

        // Single-register instance: combinational ready and full throughput.
        offer(1, 16'h5501, 1'b1);
        applyStimulus(1, 1'b1, 16'h5502, ctrlOf(16'h5502), 1'b0, 1'b0, acc);
        checkOutput("singleStallAccept", {31'd0, acc}, 32'd0);
        t0 = cycleCount;
        for (int i = 2; i < 8; i++) offer(1, 16'h5500 + 16'(i), 1'b1);
        checkOutput("singleStreamCycles", cycleCount - t0, 32'd6);
        drain(1);

        // Asynchronous reset between edges with the skid instance full.
        offer(0, 16'h6601, 1'b1);
        offer(0, 16'h6602, 1'b0);
        checkOutput("preResetOccupancy", {30'd0, aOccupancy}, 32'd2);
        #2 CLEAR = 1'b0;
        #1 checkIdle("asyncReset");
        expQ.delete();
        lastOut[0] = '0;
        lastOut[1] = '0;
        @(negedge CLOCK);
        CLEAR = 1'b1;
        applyStimulus(0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, acc);
        offer(0, 16'h7777, 1'b1);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
